// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Purpose : Types and constants shared by the ALU datapath and the streaming
//           sort engine.
//   W        word width (signed two's complement)
//   state_t  sort engine FSM states (IDLE/LOAD/SORT/DRAIN)
//   PAD_MAX  pad word for ascending batches (sorts after every real word)
//   PAD_MIN  pad word for descending batches (sorts after every real word)
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SORT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [W-1:0] PAD_MAX = 16'h7FFF;
    localparam logic [W-1:0] PAD_MIN = 16'h8000;

endpackage

// File: rtl/cmp_swap16.sv
// -----------------------------------------------------------------------------
// cmp_swap16
// Purpose : Combinational signed compare-exchange cell for the sort network.
// Ports   :
//   a, b   in   W   operands from the lower and the upper slot of a pair
//   desc   in   1   0: lo gets the smaller word, 1: lo gets the larger word
//   lo     out  W   word for the lower slot
//   hi     out  W   word for the upper slot
// Words are swapped only on strict inequality, so equal words keep their
// slot order and the network stays stable.
// -----------------------------------------------------------------------------
module cmp_swap16
    import alu_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         desc,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi
);

    // One extra bit keeps the difference exact across the full signed range
    // (32767 - (-32768) would wrap in 16 bits).
    logic [W:0] w_diff;
    logic       w_a_lt_b;
    logic       w_a_gt_b;
    logic       w_swap;

    assign w_diff   = {a[W-1], a} - {b[W-1], b};
    assign w_a_lt_b = w_diff[W];
    assign w_a_gt_b = !w_diff[W] && (w_diff != '0);
    assign w_swap   = desc ? w_a_lt_b : w_a_gt_b;

    assign lo = w_swap ? b : a;
    assign hi = w_swap ? a : b;

endmodule

// File: rtl/sort_stream16.sv
// -----------------------------------------------------------------------------
// sort_stream16
// Purpose : Streaming sort engine. Loads a batch of up to DEPTH signed words,
//           sorts it in place with an odd-even transposition network (one pass
//           per cycle, DEPTH passes), then streams the sorted words out.
// Ports   :
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   input word valid
//   in_ready   out  1   engine accepts a word (IDLE/LOAD)
//   in_data    in   W   signed input word
//   in_last    in   1   final word of the batch
//   out_valid  out  1   sorted word valid (DRAIN)
//   out_ready  in   1   downstream accepts the word
//   out_data   out  W   sorted word
//   out_last   out  1   final sorted word
//   busy       out  1   engine not in IDLE
//   desc       in   1   sort direction, 1 = descending (SORT_DESC_PORT_EN only)
// Build macro : SORT_DESC_PORT_EN adds the desc port; without it the engine
//               always sorts ascending.
// -----------------------------------------------------------------------------
module sort_stream16
    import alu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy
`ifdef SORT_DESC_PORT_EN
    ,
    input  logic         desc
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int NP = DEPTH / 2;

    state_t         r_state;
    state_t         w_state_next;
    logic [W-1:0]   r_slot [DEPTH];
    logic [W-1:0]   w_next [DEPTH];
    logic [W-1:0]   w_a    [NP];
    logic [W-1:0]   w_b    [NP];
    logic [W-1:0]   w_lo   [NP];
    logic [W-1:0]   w_hi   [NP];
    logic [CW-1:0]  r_count;
    logic [CW-1:0]  r_pass;
    logic [CW-1:0]  r_rd_ptr;
    logic           w_in_fire;
    logic           w_out_fire;
    logic           w_load_done;
    logic           w_sort_done;
    logic           w_sort_desc;
    logic [W-1:0]   w_pad;

`ifdef SORT_DESC_PORT_EN
    logic           r_desc;
    logic           w_pad_desc;

    // The batch that finishes loading on its first word has not latched desc
    // yet, so pad selection looks at the live port while still in IDLE.
    assign w_pad_desc  = (r_state == ST_IDLE) ? desc : r_desc;
    assign w_pad       = w_pad_desc ? PAD_MIN : PAD_MAX;
    assign w_sort_desc = r_desc;
`else
    assign w_pad       = PAD_MAX;
    assign w_sort_desc = 1'b0;
`endif

    assign in_ready    = (r_state == ST_IDLE) || (r_state == ST_LOAD);
    assign out_valid   = (r_state == ST_DRAIN);
    assign busy        = (r_state != ST_IDLE);
    assign out_last    = out_valid && (r_rd_ptr == r_count - 1'b1);
    assign w_in_fire   = in_valid && in_ready;
    assign w_out_fire  = out_valid && out_ready;
    // A full buffer ends the batch even without in_last.
    assign w_load_done = w_in_fire && (in_last || (r_count == CW'(DEPTH - 1)));
    assign w_sort_done = (r_pass == CW'(DEPTH));

    // Compare-exchange cells: even passes pair (2k,2k+1), odd passes pair
    // (2k+1,2k+2). The last cell has no odd-pass partner and is idle then.
    generate
        for (genvar gi = 0; gi < NP; gi++) begin : g_cell
            if (gi < NP - 1) begin : g_shared
                assign w_a[gi] = r_pass[0] ? r_slot[2*gi+1] : r_slot[2*gi];
                assign w_b[gi] = r_pass[0] ? r_slot[2*gi+2] : r_slot[2*gi+1];
            end else begin : g_even_only
                assign w_a[gi] = r_slot[2*gi];
                assign w_b[gi] = r_slot[2*gi+1];
            end
            cmp_swap16 u_cmp (
                .a    (w_a[gi]),
                .b    (w_b[gi]),
                .desc (w_sort_desc),
                .lo   (w_lo[gi]),
                .hi   (w_hi[gi])
            );
        end

        // Route cell outputs back to slots for the current pass parity.
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_route
            if (gi == 0) begin : g_first
                assign w_next[gi] = r_pass[0] ? r_slot[gi] : w_lo[0];
            end else if (gi == DEPTH - 1) begin : g_final
                assign w_next[gi] = r_pass[0] ? r_slot[gi] : w_hi[NP-1];
            end else if ((gi % 2) == 1) begin : g_odd
                assign w_next[gi] = r_pass[0] ? w_lo[(gi-1)/2] : w_hi[gi/2];
            end else begin : g_even
                assign w_next[gi] = r_pass[0] ? w_hi[gi/2-1] : w_lo[gi/2];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_in_fire) w_state_next = w_load_done ? ST_SORT : ST_LOAD;
            ST_LOAD:  if (w_load_done) w_state_next = ST_SORT;
            ST_SORT:  if (w_sort_done) w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_out_fire && out_last) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_slot[i] <= '0;
            end
            r_count  <= '0;
            r_pass   <= '0;
            r_rd_ptr <= '0;
`ifdef SORT_DESC_PORT_EN
            r_desc   <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_in_fire && (r_count == CW'(i))) begin
                    r_slot[i] <= in_data;
                end else if (w_load_done && (CW'(i) > r_count)) begin
                    r_slot[i] <= w_pad;
                end else if ((r_state == ST_SORT) && !w_sort_done) begin
                    r_slot[i] <= w_next[i];
                end
            end

            if (w_in_fire) begin
                r_count <= r_count + 1'b1;
            end
`ifdef SORT_DESC_PORT_EN
            if (w_in_fire && (r_state == ST_IDLE)) begin
                r_desc <= desc;
            end
`endif
            if (w_load_done) begin
                r_pass <= '0;
            end else if ((r_state == ST_SORT) && !w_sort_done) begin
                r_pass <= r_pass + 1'b1;
            end

            if (w_out_fire) begin
                if (out_last) begin
                    r_count  <= '0;
                    r_pass   <= '0;
                    r_rd_ptr <= '0;
                end else begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        if (r_state == ST_DRAIN) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_rd_ptr == CW'(i)) begin
                    out_data = r_slot[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_sort_stream16.sv
// -----------------------------------------------------------------------------
// tb_sort_stream16
// Purpose : Self-checking bench for sort_stream16. Batches are driven over the
//           input handshake, the sorted stream is collected, and results are
//           compared against a plain insertion-sort reference of each batch.
// Build macro : SORT_DESC_PORT_EN enables the descending-order scenario.
// -----------------------------------------------------------------------------
module tb_sort_stream16;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;
`ifdef SORT_DESC_PORT_EN
    logic        desc;
`endif

    sort_stream16 #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
`ifdef SORT_DESC_PORT_EN
        ,
        .desc      (desc)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int q_in[$];
    int q_exp[$];
    int q_out[$];
    bit q_lastf[$];
    int acc_cyc;
    int first_cyc;
    int hold_viol;
    int rdy_busy;
    int timeout;
    int gap_max;
    int ready_mode;   // 0: always ready, 1: toggling, 2: random
    bit omit_last;
    bit desc_val;
    bit desc_flip;

    // Reference: stable insertion sort of the input batch.
    task automatic build_expected(input bit dsc);
        int key;
        int j;
        q_exp = q_in;
        for (int i = 1; i < q_exp.size(); i++) begin
            key = q_exp[i];
            j = i - 1;
            while (j >= 0 && (dsc ? (q_exp[j] < key) : (q_exp[j] > key))) begin
                q_exp[j+1] = q_exp[j];
                j--;
            end
            q_exp[j+1] = key;
        end
    endtask

    function automatic int rand_word();
        int sel;
        int v;
        sel = $urandom_range(3, 0);
        case (sel)
            0: begin
                case ($urandom_range(4, 0))
                    0: v = -32768;
                    1: v = 32767;
                    2: v = -1;
                    3: v = 1;
                    default: v = 0;
                endcase
            end
            1: v = $urandom_range(8, 0) - 4;
            default: v = int'($signed(16'($urandom)));
        endcase
        return v;
    endfunction

    task automatic drive_batch();
        int bound;
        int g;
        for (int k = 0; k < q_in.size(); k++) begin
            g = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
            repeat (g) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 16'(q_in[k]);
            in_last  = (k == q_in.size() - 1) && !(omit_last && q_in.size() == DEPTH);
`ifdef SORT_DESC_PORT_EN
            if (k == 0) desc = desc_val;
            else if (desc_flip) desc = ~desc_val;
`endif
            bound = 0;
            while (!in_ready && bound < 200) begin
                @(negedge clk);
                bound++;
            end
            if (bound >= 200) begin
                timeout++;
                break;
            end
            @(posedge clk);
            #1;
            acc_cyc = cyc;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic collect(input int max_words);
        int n;
        int t;
        bit done;
        bit stall;
        logic [15:0] prevd;
        q_out.delete();
        q_lastf.delete();
        first_cyc = -1;
        hold_viol = 0;
        rdy_busy  = 0;
        n = 0;
        t = 0;
        done = 1'b0;
        stall = 1'b0;
        prevd = '0;
        out_ready = 1'b0;
        while (!done && t < 3000) begin
            @(negedge clk);
            t++;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(1, 0));
            endcase
            if (busy && in_ready) rdy_busy++;
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (stall && out_data !== prevd) hold_viol++;
                if (out_ready) begin
                    q_out.push_back(int'($signed(out_data)));
                    q_lastf.push_back(out_last);
                    n++;
                    if (out_last || n >= max_words) done = 1'b1;
                end
                stall = !out_ready;
                prevd = out_data;
            end else begin
                stall = 1'b0;
            end
        end
        if (!done) timeout++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        out_ready = 1'b0;
`ifdef SORT_DESC_PORT_EN
        desc = 1'b0;
`endif
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_full_ascending();
        q_in = '{5, -3, 7, 0, -32768, 32767, 2, 2};
        build_expected(1'b0);
        timeout = 0; gap_max = 0; ready_mode = 0; omit_last = 0;
        drive_batch();
        collect(DEPTH);
        checks++; if (timeout !== 0) begin errors++; $display("FAIL full_timeout: got %0d expected 0", timeout); end
        checks++; if (q_out.size() !== 8) begin errors++; $display("FAIL full_count: got %0d expected 8", q_out.size()); end
        for (int i = 0; i < q_exp.size() && i < q_out.size(); i++) begin
            checks++; if (q_out[i] !== q_exp[i]) begin errors++; $display("FAIL full_data[%0d]: got %0d expected %0d", i, q_out[i], q_exp[i]); end
            checks++; if (q_lastf[i] !== (i == 7)) begin errors++; $display("FAIL full_last[%0d]: got %b expected %b", i, q_lastf[i], (i == 7)); end
        end
        checks++; if (first_cyc - acc_cyc !== DEPTH + 1) begin errors++; $display("FAIL full_latency: got %0d expected %0d", first_cyc - acc_cyc, DEPTH + 1); end
        $display("test_full_ascending: %0d words out, latency %0d", q_out.size(), first_cyc - acc_cyc);
    endtask

    task automatic test_short();
        q_in = '{10, -1, 4};
        build_expected(1'b0);
        timeout = 0; gap_max = 0; ready_mode = 0; omit_last = 0;
        drive_batch();
        collect(DEPTH);
        @(negedge clk);
        checks++; if (timeout !== 0) begin errors++; $display("FAIL short_timeout: got %0d expected 0", timeout); end
        checks++; if (q_out.size() !== 3) begin errors++; $display("FAIL short_count: got %0d expected 3", q_out.size()); end
        for (int i = 0; i < q_exp.size() && i < q_out.size(); i++) begin
            checks++; if (q_out[i] !== q_exp[i]) begin errors++; $display("FAIL short_data[%0d]: got %0d expected %0d", i, q_out[i], q_exp[i]); end
        end
        checks++; if (q_lastf.size() == 3 && q_lastf[2] !== 1'b1) begin errors++; $display("FAIL short_last: got %b expected 1", q_lastf[2]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL short_busy_after: got %b expected 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL short_in_ready_after: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL short_no_pad: got out_valid %b expected 0", out_valid); end
        checks++; if (first_cyc - acc_cyc !== DEPTH + 1) begin errors++; $display("FAIL short_latency: got %0d expected %0d", first_cyc - acc_cyc, DEPTH + 1); end
        $display("test_short: %0d words out", q_out.size());
    endtask

    task automatic test_backpressure();
        q_in.delete();
        for (int i = 0; i < DEPTH; i++) q_in.push_back(rand_word());
        build_expected(1'b0);
        timeout = 0; gap_max = 1; ready_mode = 1; omit_last = 0;
        drive_batch();
        collect(DEPTH);
        checks++; if (timeout !== 0) begin errors++; $display("FAIL bp_timeout: got %0d expected 0", timeout); end
        checks++; if (q_out.size() !== DEPTH) begin errors++; $display("FAIL bp_count: got %0d expected %0d", q_out.size(), DEPTH); end
        for (int i = 0; i < q_exp.size() && i < q_out.size(); i++) begin
            checks++; if (q_out[i] !== q_exp[i]) begin errors++; $display("FAIL bp_data[%0d]: got %0d expected %0d", i, q_out[i], q_exp[i]); end
        end
        checks++; if (hold_viol !== 0) begin errors++; $display("FAIL bp_hold: got %0d changes expected 0", hold_viol); end
        checks++; if (rdy_busy !== 0) begin errors++; $display("FAIL bp_in_ready_busy: got %0d cycles expected 0", rdy_busy); end
        $display("test_backpressure: %0d words out", q_out.size());
    endtask

    task automatic test_mid_reset();
        q_in.delete();
        for (int i = 0; i < DEPTH; i++) q_in.push_back(rand_word());
        build_expected(1'b0);
        timeout = 0; gap_max = 0; ready_mode = 0; omit_last = 0;
        drive_batch();
        collect(2);
        checks++; if (q_out.size() !== 2) begin errors++; $display("FAIL mr_partial_count: got %0d expected 2", q_out.size()); end
        for (int i = 0; i < 2 && i < q_out.size(); i++) begin
            checks++; if (q_out[i] !== q_exp[i]) begin errors++; $display("FAIL mr_partial_data[%0d]: got %0d expected %0d", i, q_out[i], q_exp[i]); end
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_busy: got %b expected 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mr_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL mr_out_data: got %h expected 0000", out_data); end
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q_in = '{1, 0};
        build_expected(1'b0);
        drive_batch();
        collect(DEPTH);
        checks++; if (timeout !== 0) begin errors++; $display("FAIL mr_timeout: got %0d expected 0", timeout); end
        checks++; if (q_out.size() !== 2) begin errors++; $display("FAIL mr_new_count: got %0d expected 2", q_out.size()); end
        for (int i = 0; i < q_exp.size() && i < q_out.size(); i++) begin
            checks++; if (q_out[i] !== q_exp[i]) begin errors++; $display("FAIL mr_new_data[%0d]: got %0d expected %0d", i, q_out[i], q_exp[i]); end
        end
        $display("test_mid_reset: new batch %0d words out", q_out.size());
    endtask

    task automatic test_overflow();
        q_in = '{32767, -32768, -1, 1};
        build_expected(1'b0);
        timeout = 0; gap_max = 0; ready_mode = 0; omit_last = 0;
        drive_batch();
        collect(DEPTH);
        checks++; if (q_out.size() !== 4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", q_out.size()); end
        for (int i = 0; i < q_exp.size() && i < q_out.size(); i++) begin
            checks++; if (q_out[i] !== q_exp[i]) begin errors++; $display("FAIL ovf_data[%0d]: got %0d expected %0d", i, q_out[i], q_exp[i]); end
        end
        $display("test_overflow: %0d words out", q_out.size());
    endtask

`ifdef SORT_DESC_PORT_EN
    task automatic test_desc();
        q_in = '{1, -1, 3};
        build_expected(1'b1);
        timeout = 0; gap_max = 0; ready_mode = 0; omit_last = 0;
        desc_val = 1'b1; desc_flip = 1'b1;
        drive_batch();
        collect(DEPTH);
        checks++; if (q_out.size() !== 3) begin errors++; $display("FAIL desc_count: got %0d expected 3", q_out.size()); end
        for (int i = 0; i < q_exp.size() && i < q_out.size(); i++) begin
            checks++; if (q_out[i] !== q_exp[i]) begin errors++; $display("FAIL desc_data[%0d]: got %0d expected %0d", i, q_out[i], q_exp[i]); end
        end
        q_in = '{-32768, 5};
        build_expected(1'b1);
        desc_flip = 1'b0;
        drive_batch();
        collect(DEPTH);
        checks++; if (q_out.size() !== 2) begin errors++; $display("FAIL desc_pad_count: got %0d expected 2", q_out.size()); end
        for (int i = 0; i < q_exp.size() && i < q_out.size(); i++) begin
            checks++; if (q_out[i] !== q_exp[i]) begin errors++; $display("FAIL desc_pad_data[%0d]: got %0d expected %0d", i, q_out[i], q_exp[i]); end
        end
        desc_val = 1'b0;
        $display("test_desc: %0d words out", q_out.size());
    endtask
`endif

    task automatic test_random();
        int len;
        for (int b = 0; b < 12; b++) begin
            len = (b == 0) ? 1 : $urandom_range(DEPTH, 1);
            q_in.delete();
            for (int i = 0; i < len; i++) q_in.push_back(rand_word());
`ifdef SORT_DESC_PORT_EN
            desc_val = 1'($urandom_range(1, 0));
            desc_flip = 1'($urandom_range(1, 0));
`endif
            build_expected(desc_val);
            timeout = 0; gap_max = 2;
            ready_mode = $urandom_range(2, 0);
            omit_last = 1'($urandom_range(1, 0));
            drive_batch();
            collect(DEPTH);
            checks++; if (timeout !== 0) begin errors++; $display("FAIL rnd%0d_timeout: got %0d expected 0", b, timeout); end
            checks++; if (q_out.size() !== len) begin errors++; $display("FAIL rnd%0d_count: got %0d expected %0d", b, q_out.size(), len); end
            for (int i = 0; i < q_exp.size() && i < q_out.size(); i++) begin
                checks++; if (q_out[i] !== q_exp[i]) begin errors++; $display("FAIL rnd%0d_data[%0d]: got %0d expected %0d", b, i, q_out[i], q_exp[i]); end
                checks++; if (q_lastf[i] !== (i == len - 1)) begin errors++; $display("FAIL rnd%0d_last[%0d]: got %b expected %b", b, i, q_lastf[i], (i == len - 1)); end
            end
            checks++; if (first_cyc - acc_cyc !== DEPTH + 1) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", b, first_cyc - acc_cyc, DEPTH + 1); end
            checks++; if (hold_viol !== 0) begin errors++; $display("FAIL rnd%0d_hold: got %0d expected 0", b, hold_viol); end
            $display("test_random batch %0d: len %0d mode %0d desc %0b out %0d", b, len, ready_mode, desc_val, q_out.size());
        end
        desc_val = 1'b0;
        desc_flip = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish before 900000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        desc_val = 1'b0;
        desc_flip = 1'b0;
        omit_last = 1'b0;
        test_reset();
        test_full_ascending();
        test_short();
        test_backpressure();
        test_mid_reset();
        test_overflow();
`ifdef SORT_DESC_PORT_EN
        test_desc();
`endif
        test_random();
        do_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
